// File: rtl/pipeline_pkg.sv
// Shared widths, memory-stage state encoding and writeback record for the pipeline.
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH        = 64;
  localparam int unsigned REG_INDEX_BITS    = 5;
  localparam int unsigned THREAD_INDEX_BITS = 3;
  localparam int unsigned IMMEDIATE_WIDTH   = 16;
  localparam int unsigned ADDR_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [THREAD_INDEX_BITS-1:0] thread_index;
    logic [REG_INDEX_BITS-1:0]    reg_index;
    logic [DATA_WIDTH-1:0]        data;
  } wb_rec_t;

endpackage

// File: rtl/mem_stage_if.sv
// Upstream instruction, data-memory and writeback signals of the memory stage.
interface mem_stage_if #(
  parameter int unsigned IMMEDIATE_WIDTH   = pipeline_pkg::IMMEDIATE_WIDTH,
  parameter int unsigned DATA_WIDTH        = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned REG_INDEX_BITS    = pipeline_pkg::REG_INDEX_BITS,
  parameter int unsigned THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
  parameter int unsigned ADDR_WIDTH        = pipeline_pkg::ADDR_WIDTH
);
  import pipeline_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic                         in_increment_flag;
  logic                         in_load_word_flag;
  logic                         in_store_word_flag;
  logic [IMMEDIATE_WIDTH-1:0]   in_immediate;
  logic [THREAD_INDEX_BITS-1:0] in_thread_index;
  logic [REG_INDEX_BITS-1:0]    in_reg_index;
  logic [DATA_WIDTH-1:0]        in_data;

  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [DATA_WIDTH-1:0]        mem_wdata;
  logic                         mem_gnt;
  logic                         mem_rvalid;
  logic [DATA_WIDTH-1:0]        mem_rdata;

  logic                         wb_valid;
  logic [THREAD_INDEX_BITS-1:0] wb_thread_index;
  logic [REG_INDEX_BITS-1:0]    wb_reg_index;
  logic [DATA_WIDTH-1:0]        wb_data;
  logic                         illegal_op;

  // Environment side: upstream stage, data memory and register file.
  modport master (
    output in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
    output in_immediate, in_thread_index, in_reg_index, in_data,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_thread_index, wb_reg_index, wb_data, illegal_op
  );

  modport slave (
    input  in_valid, in_increment_flag, in_load_word_flag, in_store_word_flag,
    input  in_immediate, in_thread_index, in_reg_index, in_data,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_thread_index, wb_reg_index, wb_data, illegal_op
  );

endinterface

// File: rtl/mem_req_buffer.sv
// Holding register for the accepted instruction; drives a request that stays stable until grant.
module mem_req_buffer #(
  parameter int unsigned IMMEDIATE_WIDTH   = pipeline_pkg::IMMEDIATE_WIDTH,
  parameter int unsigned DATA_WIDTH        = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned REG_INDEX_BITS    = pipeline_pkg::REG_INDEX_BITS,
  parameter int unsigned THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
  parameter int unsigned ADDR_WIDTH        = pipeline_pkg::ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_capture,
  input  logic                         i_mem_op,
  input  logic                         i_store,
  input  logic                         i_grant,
  input  logic [IMMEDIATE_WIDTH-1:0]   i_immediate,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic [REG_INDEX_BITS-1:0]    i_reg_index,
  input  logic [THREAD_INDEX_BITS-1:0] i_thread_index,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [DATA_WIDTH-1:0]        o_mem_wdata,
  output logic [REG_INDEX_BITS-1:0]    o_reg_index,
  output logic [THREAD_INDEX_BITS-1:0] o_thread_index
);
  import pipeline_pkg::*;

  logic                         r_req;
  logic                         r_we;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]        r_wdata;
  logic [REG_INDEX_BITS-1:0]    r_reg_index;
  logic [THREAD_INDEX_BITS-1:0] r_thread_index;

  // Capture happens only in IDLE and grant only in REQ, so request fields never move mid-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_reg_index    <= '0;
      r_thread_index <= '0;
    end else if (i_capture) begin
      r_reg_index    <= i_reg_index;
      r_thread_index <= i_thread_index;
      if (i_mem_op) begin
        r_req   <= 1'b1;
        r_we    <= i_store;
        r_addr  <= i_immediate[ADDR_WIDTH-1:0];
        r_wdata <= i_store ? i_data : '0;
      end
    end else if (i_grant) begin
      r_req <= 1'b0;
    end
  end

  assign o_mem_req      = r_req;
  assign o_mem_we       = r_we;
  assign o_mem_addr     = r_addr;
  assign o_mem_wdata    = r_wdata;
  assign o_reg_index    = r_reg_index;
  assign o_thread_index = r_thread_index;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one load/store per instruction over req/gnt/rvalid, registered writeback.
module mem_stage #(
  parameter int unsigned IMMEDIATE_WIDTH   = pipeline_pkg::IMMEDIATE_WIDTH,
  parameter int unsigned DATA_WIDTH        = pipeline_pkg::DATA_WIDTH,
  parameter int unsigned REG_INDEX_BITS    = pipeline_pkg::REG_INDEX_BITS,
  parameter int unsigned THREAD_INDEX_BITS = pipeline_pkg::THREAD_INDEX_BITS,
  parameter int unsigned ADDR_WIDTH        = pipeline_pkg::ADDR_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);
  import pipeline_pkg::*;

  mem_state_t                   r_state;
  logic                         r_wb_valid;
  logic                         r_illegal;
  logic [THREAD_INDEX_BITS-1:0] r_wb_thread_index;
  logic [REG_INDEX_BITS-1:0]    r_wb_reg_index;
  logic [DATA_WIDTH-1:0]        r_wb_data;

  logic                         w_accept;
  logic                         w_mem_op;
  logic                         w_grant;
  logic [REG_INDEX_BITS-1:0]    w_hold_reg_index;
  logic [THREAD_INDEX_BITS-1:0] w_hold_thread_index;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_mem_op = bus.in_load_word_flag ^ bus.in_store_word_flag;
  assign w_grant  = (r_state == REQ) && bus.mem_gnt;

  mem_req_buffer #(
    .IMMEDIATE_WIDTH  (IMMEDIATE_WIDTH),
    .DATA_WIDTH       (DATA_WIDTH),
    .REG_INDEX_BITS   (REG_INDEX_BITS),
    .THREAD_INDEX_BITS(THREAD_INDEX_BITS),
    .ADDR_WIDTH       (ADDR_WIDTH)
  ) u_req_buffer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_capture     (w_accept),
    .i_mem_op      (w_mem_op),
    .i_store       (bus.in_store_word_flag),
    .i_grant       (w_grant),
    .i_immediate   (bus.in_immediate),
    .i_data        (bus.in_data),
    .i_reg_index   (bus.in_reg_index),
    .i_thread_index(bus.in_thread_index),
    .o_mem_req     (bus.mem_req),
    .o_mem_we      (bus.mem_we),
    .o_mem_addr    (bus.mem_addr),
    .o_mem_wdata   (bus.mem_wdata),
    .o_reg_index   (w_hold_reg_index),
    .o_thread_index(w_hold_thread_index)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_wb_valid        <= 1'b0;
      r_illegal         <= 1'b0;
      r_wb_thread_index <= '0;
      r_wb_reg_index    <= '0;
      r_wb_data         <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            if (w_mem_op) begin
              r_state <= REQ;
            end else if (bus.in_load_word_flag) begin
              r_illegal <= 1'b1;
            end else begin
              r_wb_valid        <= 1'b1;
              r_wb_data         <= bus.in_data;
              r_wb_reg_index    <= bus.in_reg_index;
              r_wb_thread_index <= bus.in_thread_index;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            if (bus.mem_we) begin
              r_state <= IDLE;
            end else if (bus.mem_rvalid) begin
              // Response together with grant completes the load without visiting WAIT_RSP.
              r_state           <= IDLE;
              r_wb_valid        <= 1'b1;
              r_wb_data         <= bus.mem_rdata;
              r_wb_reg_index    <= w_hold_reg_index;
              r_wb_thread_index <= w_hold_thread_index;
            end else begin
              r_state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (bus.mem_rvalid) begin
            r_state           <= IDLE;
            r_wb_valid        <= 1'b1;
            r_wb_data         <= bus.mem_rdata;
            r_wb_reg_index    <= w_hold_reg_index;
            r_wb_thread_index <= w_hold_thread_index;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready        = rst_n && (r_state == IDLE);
  assign bus.wb_valid        = r_wb_valid;
  assign bus.wb_thread_index = r_wb_thread_index;
  assign bus.wb_reg_index    = r_wb_reg_index;
  assign bus.wb_data         = r_wb_data;
  assign bus.illegal_op      = r_illegal;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random instructions against a memory/writeback model.
module tb_mem_stage;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Data-memory contents as seen by the bench; unwritten words have an address-derived pattern.
  logic [63:0] mem_model [logic [15:0]];

  function automatic logic [63:0] mem_rd(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a, ~a, a ^ 16'h5A5A, 16'h1357};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid           = 1'b0;
    bus.in_increment_flag  = 1'b0;
    bus.in_load_word_flag  = 1'b0;
    bus.in_store_word_flag = 1'b0;
    bus.in_immediate       = '0;
    bus.in_thread_index    = '0;
    bus.in_reg_index       = '0;
    bus.in_data            = '0;
    bus.mem_gnt            = 1'b0;
    bus.mem_rvalid         = 1'b0;
    bus.mem_rdata          = '0;
  endtask

  // Present one instruction for a single cycle; it must be accepted.
  task automatic issue(input logic ld, input logic st, input logic inc, input logic [15:0] imm,
                       input logic [63:0] d, input logic [4:0] r, input logic [2:0] t);
    chk("in_ready_before_issue", bus.in_ready, 1);
    bus.in_valid           = 1'b1;
    bus.in_load_word_flag  = ld;
    bus.in_store_word_flag = st;
    bus.in_increment_flag  = inc;
    bus.in_immediate       = imm;
    bus.in_data            = d;
    bus.in_reg_index       = r;
    bus.in_thread_index    = t;
    tick();
    bus.in_valid           = 1'b0;
    bus.in_load_word_flag  = 1'b0;
    bus.in_store_word_flag = 1'b0;
    bus.in_increment_flag  = 1'b0;
  endtask

  task automatic check_wb(input string tag, input wb_rec_t exp);
    chk({tag, "_wb_valid"}, bus.wb_valid, 1);
    chk({tag, "_wb_data"}, bus.wb_data, exp.data);
    chk({tag, "_wb_reg"}, bus.wb_reg_index, exp.reg_index);
    chk({tag, "_wb_thread"}, bus.wb_thread_index, exp.thread_index);
  endtask

  task automatic pass_op(input logic inc, input logic [63:0] d, input logic [4:0] r,
                         input logic [2:0] t);
    wb_rec_t exp;
    exp = '{thread_index: t, reg_index: r, data: d};
    issue(1'b0, 1'b0, inc, 16'($urandom), d, r, t);
    check_wb("pass", exp);
    chk("pass_ready", bus.in_ready, 1);
    chk("pass_no_req", bus.mem_req, 0);
    tick();
    chk("pass_pulse_end", bus.wb_valid, 0);
    chk("pass_data_held", bus.wb_data, d);
  endtask

  task automatic illegal_op_case(input logic [63:0] d);
    issue(1'b1, 1'b1, 1'b0, 16'h0BAD, d, 5'd1, 3'd1);
    chk("illegal_pulse", bus.illegal_op, 1);
    chk("illegal_no_req", bus.mem_req, 0);
    chk("illegal_no_wb", bus.wb_valid, 0);
    chk("illegal_ready", bus.in_ready, 1);
    tick();
    chk("illegal_pulse_end", bus.illegal_op, 0);
    chk("illegal_no_req2", bus.mem_req, 0);
  endtask

  // Load or store with gw cycles of grant wait; loads then wait rw cycles for the response
  // unless same is set, in which case the response arrives with the grant.
  task automatic mem_op(input logic st, input logic [15:0] imm, input logic [63:0] d,
                        input logic [4:0] r, input logic [2:0] t, input int gw, input int rw,
                        input bit same);
    logic [15:0] seen_addr;
    wb_rec_t     exp;
    issue(~st, st, 1'b0, imm, d, r, t);
    for (int i = 0; i < gw; i++) begin
      chk("req_held", bus.mem_req, 1);
      chk("we_held", bus.mem_we, st);
      chk("addr_held", bus.mem_addr, imm);
      chk("wdata_held", bus.mem_wdata, st ? d : 64'h0);
      chk("ready_busy", bus.in_ready, 0);
      chk("no_wb_busy", bus.wb_valid, 0);
      if (!st) begin
        bus.mem_rvalid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      tick();
      bus.mem_rvalid = 1'b0;
    end
    chk("req_at_gnt", bus.mem_req, 1);
    chk("we_at_gnt", bus.mem_we, st);
    chk("addr_at_gnt", bus.mem_addr, imm);
    chk("wdata_at_gnt", bus.mem_wdata, st ? d : 64'h0);
    seen_addr   = bus.mem_addr;
    bus.mem_gnt = 1'b1;
    if (st) begin
      mem_model[seen_addr] = bus.mem_wdata;
    end else if (same) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_rd(seen_addr);
    end
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    chk("req_dropped", bus.mem_req, 0);
    if (st) begin
      chk("store_no_wb", bus.wb_valid, 0);
      chk("store_ready", bus.in_ready, 1);
      return;
    end
    if (!same) begin
      for (int i = 0; i < rw; i++) begin
        chk("rsp_wait_no_wb", bus.wb_valid, 0);
        chk("rsp_wait_ready", bus.in_ready, 0);
        chk("rsp_wait_no_req", bus.mem_req, 0);
        tick();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_rd(seen_addr);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    exp = '{thread_index: t, reg_index: r, data: mem_rd(imm)};
    check_wb("load", exp);
    chk("load_ready", bus.in_ready, 1);
    tick();
    chk("load_pulse_end", bus.wb_valid, 0);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_reg", bus.wb_reg_index, 0);
    chk("rst_wb_thread", bus.wb_thread_index, 0);
    chk("rst_illegal", bus.illegal_op, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", bus.in_ready, 1);

    // Directed cases
    pass_op(1'b1, 64'h0000_0000_0000_00FF, 5'd7, 3'd2);
    mem_op(1'b1, 16'h0040, 64'h1234, 5'd4, 3'd1, 3, 0, 1'b0);
    mem_model[16'h0010] = 64'hDEAD_BEEF;
    mem_op(1'b0, 16'h0010, 64'h0, 5'd3, 3'd0, 0, 0, 1'b1);
    mem_op(1'b0, 16'h0040, 64'h0, 5'd12, 3'd6, 2, 2, 1'b0);
    illegal_op_case(64'h77);

    // Back-to-back pass-through, one per cycle
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d;
      d = {32'(i + 1), $urandom};
      chk("b2b_ready", bus.in_ready, 1);
      bus.in_valid        = 1'b1;
      bus.in_data         = d;
      bus.in_reg_index    = 5'(i + 8);
      bus.in_thread_index = 3'(i);
      tick();
      chk("b2b_wb_valid", bus.wb_valid, 1);
      chk("b2b_wb_data", bus.wb_data, d);
      chk("b2b_wb_reg", bus.wb_reg_index, 5'(i + 8));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_end", bus.wb_valid, 0);

    // Random instruction mix
    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [15:0] imm;
      logic [63:0] d;
      kind = $urandom_range(0, 6);
      imm  = 16'($urandom_range(0, 15)) * 16'h1111;
      d    = {$urandom, $urandom};
      if (kind <= 1) pass_op(1'($urandom_range(0, 1)), d, 5'($urandom), 3'($urandom));
      else if (kind <= 3)
        mem_op(1'b1, imm, d, 5'($urandom), 3'($urandom), $urandom_range(0, 3), 0, 1'b0);
      else if (kind <= 5)
        mem_op(1'b0, imm, d, 5'($urandom), 3'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      else illegal_op_case(d);
    end

    // Reset while waiting for a load response
    pass_op(1'b0, 64'hCAFE_F00D_1234_5678, 5'd30, 3'd7);
    issue(1'b1, 1'b0, 1'b0, 16'h0020, 64'h0, 5'd9, 3'd5);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("wait_rsp_busy", bus.in_ready, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.in_ready, 0);
    chk("midrst_req", bus.mem_req, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_wb_valid", bus.wb_valid, 0);
    chk("midrst_wb_data", bus.wb_data, 0);
    chk("midrst_wb_reg", bus.wb_reg_index, 0);
    chk("midrst_wb_thread", bus.wb_thread_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("late_rsp_no_wb", bus.wb_valid, 0);
    tick();
    chk("late_rsp_no_wb2", bus.wb_valid, 0);
    chk("ready_after_midrst", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the second execute stage.
- Consumes its flags, immediate, thread index, register index and data. Performs one data-memory load or store per instruction over a request/grant/response handshake.
- Stalls upstream while the access is outstanding and delivers a registered writeback record to the register-file write port.
- Increment and pass-through operations bypass memory with one-cycle latency.

Parameters:
- IMMEDIATE_WIDTH, 16, width of the immediate; its low ADDR_WIDTH bits are the memory address
- DATA_WIDTH, 64, data and register width
- REG_INDEX_BITS, 5, register index width
- THREAD_INDEX_BITS, 3, thread index width
- ADDR_WIDTH, 16, data-memory word address width (must be <= IMMEDIATE_WIDTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_increment_flag  in  1  increment op; data already computed
- in_load_word_flag  in  1  load op
- in_store_word_flag  in  1  store op
- in_immediate  in  IMMEDIATE_WIDTH  direct address source
- in_thread_index  in  THREAD_INDEX_BITS  issuing thread
- in_reg_index  in  REG_INDEX_BITS  destination register (load/increment)
- in_data  in  DATA_WIDTH  store data, or result for increment/pass-through
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read response valid
- mem_rdata  in  DATA_WIDTH  read response data
- wb_valid  out  1  writeback record valid (single-cycle pulse)
- wb_thread_index  out  THREAD_INDEX_BITS  writeback thread
- wb_reg_index  out  REG_INDEX_BITS  writeback register
- wb_data  out  DATA_WIDTH  writeback value
- illegal_op  out  1  single-cycle pulse: load and store flags both set

Behaviour:
- Reset (async, rst_n=0) values:
  - FSM = IDLE
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - wb_valid = 0, wb_thread_index = 0, wb_reg_index = 0, wb_data = 0
  - illegal_op = 0
  - in_ready = 0 while in reset, 1 in IDLE afterwards
- Mid-operation reset aborts any access. No writeback is issued for the aborted instruction, and mem_req drops immediately.
- The FSM has three states: IDLE, REQ and WAIT_RSP. in_ready = 1 only in IDLE.
- IDLE, in_valid=1, captures all inputs into a holding register and dispatches on the flags:
  - load xor store: go to REQ and assert mem_req next cycle. mem_addr = in_immediate[ADDR_WIDTH-1:0]. mem_we = store. mem_wdata = in_data for a store, 0 for a load.
  - load and store both set: no memory access, no writeback; illegal_op pulses next cycle; stay IDLE.
  - neither set (increment or pass-through): next cycle wb_valid=1, wb_data=in_data; stay IDLE.
- REQ: mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_gnt=1. Any change before grant is a bench error.
  - gnt && store: drop mem_req next cycle, return to IDLE; no writeback.
  - gnt && load: go to WAIT_RSP, drop mem_req.
- A response in the same cycle as the grant (mem_gnt && mem_rvalid) is legal. The load completes exactly as from WAIT_RSP and the FSM goes to IDLE.
- WAIT_RSP: on mem_rvalid, the next cycle gives wb_valid=1 with wb_data=mem_rdata, wb_reg_index and wb_thread_index from the holding register; FSM returns to IDLE.
- mem_rvalid outside WAIT_RSP (and not with a grant in REQ) is ignored.
- Latencies:
  - pass-through: 1 cycle
  - store: 1 + grant wait cycles, no writeback
  - load: 2 + grant wait + response wait cycles, minimum 2 with gnt and rvalid together
- Throughput:
  - Back-to-back pass-through instructions are accepted every cycle.
  - After any memory op, the next instruction is accepted in the cycle the FSM is back in IDLE.
- wb_valid and illegal_op are single-cycle pulses. wb_data, wb_reg_index and wb_thread_index hold their last value when wb_valid=0.
- Address truncation: immediate bits above ADDR_WIDTH are ignored. There is no sign extension and no wrap detection.

Decomposition:
- Shared package pipeline_pkg holds:
  - width defaults: DATA_WIDTH, REG_INDEX_BITS, THREAD_INDEX_BITS, IMMEDIATE_WIDTH, ADDR_WIDTH
  - mem_state_t enum: IDLE, REQ, WAIT_RSP
  - a writeback record typedef: thread, reg, data
- One natural sub-module, mem_req_buffer: the holding register plus the request-stability logic.
- The FSM and writeback logic stay in mem_stage.

Test Plan:
- Pass-through: in_valid, no flags, in_data=0x0000_0000_0000_00FF, reg 7, thread 2 -> next cycle wb_valid=1, wb_data=0xFF, wb_reg_index=7, wb_thread_index=2; in_ready stays 1.
- Store with grant delay: store, imm=0x0040, data=0x1234 -> mem_req=1, mem_we=1, addr=0x0040, wdata=0x1234, held stable for 3 cycles with gnt=0; gnt=1 on cycle 4 -> mem_req drops next cycle, no wb_valid, in_ready returns to 1.
- Load with same-cycle gnt and rvalid: load, imm=0x0010, reg 3, rdata=0xDEAD_BEEF -> wb_valid=1 with wb_data=0xDEADBEEF, reg 3, 2 cycles after acceptance.
- Load with 2-cycle response wait -> in_ready=0 throughout, spurious rvalid before gnt ignored, single wb pulse with correct data.
- Illegal: load and store both set -> illegal_op pulses once, mem_req stays 0, no wb_valid.
- Reset in WAIT_RSP: assert rst_n=0 mid-load -> all outputs at reset values immediately; after release, a late rvalid produces no writeback.
